kf8259_bus_control_seq: RTL and testbench

- Parametrised successor to the KF8259 bus control logic.
- Synchronises the host CS/RD/WR/A0 bus and latches write data.
- Tracks the ICW1→ICW2→[ICW3]→[ICW4] initialisation sequence internally, issuing one-cycle strobes per individual command word instead of a shared ICW2-4 strobe.
- Holds the OCW3 read-select and poll state for the data-bus read mux; sits between the 8259 pin interface and the interrupt/priority logic.

---
 rtl/kf8259_bus_control_seq.sv | 179 +++++++++++++++++
 tb/tb_kf8259_bus_control_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/kf8259_bus_control_seq.sv
// Host bus front end for the KF8259: synchronises CS/RD/WR, latches write data,
// sequences ICW1..ICW4 and emits one-cycle per-command strobes plus OCW3 read state.
module kf8259_bus_control_seq #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  chip_select_n,
  input  logic                  read_enable_n,
  input  logic                  write_enable_n,
  input  logic                  address,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic                  write_icw1,
  output logic                  write_icw2,
  output logic                  write_icw3,
  output logic                  write_icw4,
  output logic                  write_ocw1,
  output logic                  write_ocw2,
  output logic                  write_ocw3,
  output logic                  read,
  output logic [2:0]            init_state,
  output logic                  initialized,
  output logic                  read_isr,
  output logic                  poll_command
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } init_state_t;

  // Strobe vector bit order: {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3}
  localparam logic [6:0] S_ICW1 = 7'b1000000;
  localparam logic [6:0] S_ICW2 = 7'b0100000;
  localparam logic [6:0] S_ICW3 = 7'b0010000;
  localparam logic [6:0] S_ICW4 = 7'b0001000;
  localparam logic [6:0] S_OCW1 = 7'b0000100;
  localparam logic [6:0] S_OCW2 = 7'b0000010;
  localparam logic [6:0] S_OCW3 = 7'b0000001;

  logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync, valid_sync;
  logic cs_s, rd_s, wr_s;
  logic cs_prev, wr_prev, read_prev, armed;
  logic write_event;
  logic addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  init_state_t state, state_next;
  logic [6:0] strobe, strobe_next;
  logic ic4, ic4_next, sngl, sngl_next;
  logic isr_next, poll_next;

  // valid_sync marks when the synchroniser holds real pin samples rather than reset fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_sync    <= '1;
      rd_sync    <= '1;
      wr_sync    <= '1;
      valid_sync <= '0;
    end else begin
      cs_sync[0]    <= chip_select_n;
      rd_sync[0]    <= read_enable_n;
      wr_sync[0]    <= write_enable_n;
      valid_sync[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync[i]    <= cs_sync[i-1];
        rd_sync[i]    <= rd_sync[i-1];
        wr_sync[i]    <= wr_sync[i-1];
        valid_sync[i] <= valid_sync[i-1];
      end
    end
  end

  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign rd_s = rd_sync[SYNC_STAGES-1];
  assign wr_s = wr_sync[SYNC_STAGES-1];
  assign read = ~cs_s & ~rd_s & wr_s;

  // A write edge only counts once a genuine high level has been seen since reset.
  assign write_event = armed & ~wr_prev & wr_s & ~cs_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_prev           <= 1'b1;
      wr_prev           <= 1'b1;
      read_prev         <= 1'b0;
      armed             <= 1'b0;
      addr_q            <= 1'b0;
      data_q            <= '0;
    end else begin
      cs_prev   <= cs_s;
      wr_prev   <= wr_s;
      read_prev <= read;
      armed     <= armed | (valid_sync[SYNC_STAGES-1] & wr_s);
      if (~cs_s & ~wr_s) begin
        addr_q <= address;
        data_q <= data_bus_in;
      end
    end
  end

  assign internal_data_bus = data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      strobe       <= '0;
      ic4          <= 1'b0;
      sngl         <= 1'b0;
      read_isr     <= 1'b0;
      poll_command <= 1'b0;
    end else begin
      state        <= state_next;
      strobe       <= strobe_next;
      ic4          <= ic4_next;
      sngl         <= sngl_next;
      read_isr     <= isr_next;
      poll_command <= poll_next;
    end
  end

  always_comb begin
    state_next  = state;
    strobe_next = '0;
    ic4_next    = ic4;
    sngl_next   = sngl;
    isr_next    = read_isr;
    poll_next   = poll_command;
    if (read_prev & ~read) poll_next = 1'b0;
    if (write_event) begin
      if (~addr_q && data_q[4]) begin
        strobe_next = S_ICW1;
        ic4_next    = data_q[0];
        sngl_next   = data_q[1];
        state_next  = WAIT_ICW2;
        isr_next    = 1'b0;
        poll_next   = 1'b0;
      end else if (addr_q) begin
        case (state)
          WAIT_ICW2: begin
            strobe_next = S_ICW2;
            if (!sngl)    state_next = WAIT_ICW3;
            else if (ic4) state_next = WAIT_ICW4;
            else          state_next = READY;
          end
          WAIT_ICW3: begin
            strobe_next = S_ICW3;
            state_next  = ic4 ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            strobe_next = S_ICW4;
            state_next  = READY;
          end
          READY:   strobe_next = S_OCW1;
          default: ;
        endcase
      end else if (state == READY) begin
        if (!data_q[3]) begin
          strobe_next = S_OCW2;
        end else begin
          strobe_next = S_OCW3;
          if (data_q[1]) isr_next = data_q[0];
          if (data_q[2]) poll_next = 1'b1;
        end
      end
    end
  end

  assign {write_icw1, write_icw2, write_icw3, write_icw4,
          write_ocw1, write_ocw2, write_ocw3} = strobe;
  assign init_state  = state;
  assign initialized = (state == READY);

endmodule

// File: tb/tb_kf8259_bus_control_seq.sv
// Directed bench for kf8259_bus_control_seq: bus writes push expected strobes to a
// queue that a negedge monitor pops whenever any strobe fires.
module tb_kf8259_bus_control_seq;
  localparam int DW   = 8;
  localparam int SYNC = 2;

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_ICW1 = 7'b1000000;
  localparam logic [6:0] S_ICW2 = 7'b0100000;
  localparam logic [6:0] S_ICW3 = 7'b0010000;
  localparam logic [6:0] S_ICW4 = 7'b0001000;
  localparam logic [6:0] S_OCW1 = 7'b0000100;
  localparam logic [6:0] S_OCW2 = 7'b0000010;
  localparam logic [6:0] S_OCW3 = 7'b0000001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic chip_select_n = 1'b1;
  logic read_enable_n = 1'b1;
  logic write_enable_n = 1'b1;
  logic address = 1'b0;
  logic [DW-1:0] data_bus_in = '0;
  logic [DW-1:0] internal_data_bus;
  logic write_icw1, write_icw2, write_icw3, write_icw4;
  logic write_ocw1, write_ocw2, write_ocw3;
  logic read, initialized, read_isr, poll_command;
  logic [2:0] init_state;
  logic [6:0] strobes;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  kf8259_bus_control_seq #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset),
    .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
    .write_enable_n(write_enable_n), .address(address),
    .data_bus_in(data_bus_in), .internal_data_bus(internal_data_bus),
    .write_icw1(write_icw1), .write_icw2(write_icw2),
    .write_icw3(write_icw3), .write_icw4(write_icw4),
    .write_ocw1(write_ocw1), .write_ocw2(write_ocw2), .write_ocw3(write_ocw3),
    .read(read), .init_state(init_state), .initialized(initialized),
    .read_isr(read_isr), .poll_command(poll_command)
  );

  assign strobes = {write_icw1, write_icw2, write_icw3, write_icw4,
                    write_ocw1, write_ocw2, write_ocw3};

  // clock/reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: any strobe activity must match the head of exp_q
  always @(negedge clock) begin
    if (!reset && strobes !== S_NONE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {1'b0, strobes}, 8'h00);
      end else begin
        check("strobe_order", {1'b0, strobes}, {1'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // drives one write pulse; exp is the strobe that must appear SYNC+1 edges after WR rises
  task automatic do_write(input logic a, input logic [7:0] d, input logic [6:0] exp, input logic cs);
    @(posedge clock); #1;
    chip_select_n = cs; address = a; data_bus_in = d; write_enable_n = 1'b0;
    idle(3 + $urandom_range(0, 2));
    write_enable_n = 1'b1;
    if (exp != S_NONE) exp_q.push_back(exp);
    idle(SYNC + 1);
    check("strobe_latency", {1'b0, strobes}, {1'b0, exp});
    idle(1);
    check("strobe_width", {1'b0, strobes}, 8'h00);
    chip_select_n = 1'b1;
    idle(2);
    check("sb_drained", 8'(exp_q.size()), 8'h00);
  endtask

  task automatic do_read(output logic seen);
    seen = 1'b0;
    @(posedge clock); #1;
    chip_select_n = 1'b0; read_enable_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (read) seen = 1'b1;
    end
    chip_select_n = 1'b1; read_enable_n = 1'b1;
  endtask

  initial begin
    logic seen;
    // reset values
    idle(3);
    check("rst_strobes", {1'b0, strobes}, 8'h00);
    check("rst_bus", internal_data_bus, 8'h00);
    check("rst_read", {7'b0, read}, 8'h00);
    check("rst_state", {5'b0, init_state}, 8'h00);
    check("rst_init", {7'b0, initialized}, 8'h00);
    check("rst_isr", {7'b0, read_isr}, 8'h00);
    check("rst_poll", {7'b0, poll_command}, 8'h00);
    @(negedge clock); reset = 1'b0;
    idle(SYNC + 3);

    // writes before initialisation are ignored
    do_write(1'b1, 8'h55, S_NONE, 1'b0);
    do_write(1'b0, 8'h08, S_NONE, 1'b0);
    check("preinit_state", {5'b0, init_state}, 8'd0);

    // single, IC4: ICW1, ICW2, ICW4
    do_write(1'b0, 8'h13, S_ICW1, 1'b0);
    check("single_s1", {5'b0, init_state}, 8'd1);
    do_write(1'b1, 8'h08, S_ICW2, 1'b0);
    check("single_s3", {5'b0, init_state}, 8'd3);
    do_write(1'b1, 8'h01, S_ICW4, 1'b0);
    check("single_s4", {5'b0, init_state}, 8'd4);
    check("single_init", {7'b0, initialized}, 8'd1);

    // cascade, IC4: ICW1..ICW4
    do_write(1'b0, 8'h11, S_ICW1, 1'b0);
    check("casc_s1", {5'b0, init_state}, 8'd1);
    do_write(1'b1, 8'h20, S_ICW2, 1'b0);
    check("casc_s2", {5'b0, init_state}, 8'd2);
    do_write(1'b1, 8'h04, S_ICW3, 1'b0);
    check("casc_s3", {5'b0, init_state}, 8'd3);
    check("casc_not_ready", {7'b0, initialized}, 8'd0);
    do_write(1'b1, 8'h01, S_ICW4, 1'b0);
    check("casc_s4", {5'b0, init_state}, 8'd4);

    // operational commands
    do_write(1'b1, 8'hFF, S_OCW1, 1'b0);
    check("ocw1_bus", internal_data_bus, 8'hFF);
    do_write(1'b0, 8'h20, S_OCW2, 1'b0);
    check("ocw2_bus", internal_data_bus, 8'h20);
    do_write(1'b0, 8'h0B, S_OCW3, 1'b0);
    check("ocw3_isr", {7'b0, read_isr}, 8'd1);
    check("ocw3_nopoll", {7'b0, poll_command}, 8'd0);
    do_write(1'b0, 8'h0C, S_OCW3, 1'b0);
    check("poll_set", {7'b0, poll_command}, 8'd1);
    check("poll_isr_kept", {7'b0, read_isr}, 8'd1);
    do_read(seen);
    check("read_seen", {7'b0, seen}, 8'd1);
    check("poll_during", {7'b0, poll_command}, 8'd1);
    idle(SYNC + 2);
    check("poll_cleared", {7'b0, poll_command}, 8'd0);
    check("read_keeps_bus", internal_data_bus, 8'h0C);

    // ICW1 mid-sequence restarts initialisation
    do_write(1'b0, 8'h11, S_ICW1, 1'b0);
    check("icw1_clr_isr", {7'b0, read_isr}, 8'd0);
    do_write(1'b1, 8'h20, S_ICW2, 1'b0);
    check("mid_s2", {5'b0, init_state}, 8'd2);
    do_write(1'b0, 8'h13, S_ICW1, 1'b0);
    check("mid_restart", {5'b0, init_state}, 8'd1);
    do_write(1'b1, 8'h08, S_ICW2, 1'b0);
    do_write(1'b1, 8'h01, S_ICW4, 1'b0);
    check("mid_ready", {5'b0, init_state}, 8'd4);

    // RD and WR low together: write wins
    @(posedge clock); #1;
    chip_select_n = 1'b0; address = 1'b1; data_bus_in = 8'h5A;
    read_enable_n = 1'b0; write_enable_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (read) seen = 1'b1;
    end
    check("rdwr_read_low", {7'b0, seen}, 8'd0);
    read_enable_n = 1'b1; write_enable_n = 1'b1;
    exp_q.push_back(S_OCW1);
    idle(SYNC + 1);
    check("rdwr_strobe", {1'b0, strobes}, {1'b0, S_OCW1});
    check("rdwr_read_after", {7'b0, read}, 8'd0);
    chip_select_n = 1'b1;
    idle(3);
    check("rdwr_drained", 8'(exp_q.size()), 8'h00);

    // WR with CS high: no strobe, no latch
    do_write(1'b0, 8'h77, S_NONE, 1'b1);
    check("cs_high_bus", internal_data_bus, 8'h5A);
    check("cs_high_state", {5'b0, init_state}, 8'd4);

    // reset during a write, WR still low after release
    @(posedge clock); #1;
    chip_select_n = 1'b0; address = 1'b1; data_bus_in = 8'h33; write_enable_n = 1'b0;
    idle(3);
    reset = 1'b1;
    #1;
    check("midrst_state", {5'b0, init_state}, 8'd0);
    check("midrst_bus", internal_data_bus, 8'h00);
    idle(2);
    @(negedge clock); reset = 1'b0;
    idle(SYNC + 3);
    write_enable_n = 1'b1;
    idle(SYNC + 1);
    check("midrst_nostrobe", {1'b0, strobes}, 8'h00);
    idle(3);
    chip_select_n = 1'b1;
    check("midrst_state_after", {5'b0, init_state}, 8'd0);
    check("midrst_sb", 8'(exp_q.size()), 8'h00);

    // a clean write afterwards still works
    do_write(1'b0, 8'h13, S_ICW1, 1'b0);
    check("post_rst_icw1", {5'b0, init_state}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
